// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_ctrl_pkg                                                 |
// | Description : Shared types, encodings and helpers for the memory arbiter.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_1W    = 2'b00;
    localparam logic [1:0] SIZE_4W    = 2'b01;
    localparam logic [1:0] SIZE_8W    = 2'b10;
    localparam logic [1:0] SIZE_16W   = 2'b11;
    localparam int         WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } rd_tag_t;

    function automatic logic [4:0] size_to_beats(input logic [1:0] size);
        case (size)
            SIZE_1W: return 5'd1;
            SIZE_4W: return 5'd4;
            SIZE_8W: return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter_if                                               |
// | Description : Requester and memory-side signals of the memory arbiter.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [1:0]        if_size;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              if_done;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic [1:0]        d_size;
    logic              d_rw;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_wready;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_done;

    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_data_in;
    logic [1:0]        mem_access_size;
    logic              mem_rw;
    logic              mem_enable;
    logic [31:0]       mem_data_out;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, if_size,
        output if_gnt, if_rvalid, if_rdata, if_done,
        input  d_req, d_addr, d_size, d_rw, d_wdata,
        output d_gnt, d_wready, d_rvalid, d_rdata, d_done,
        output mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
        input  mem_data_out
    );

    // Requesters plus memory
    modport master (
        output if_req, if_addr, if_size,
        input  if_gnt, if_rvalid, if_rdata, if_done,
        output d_req, d_addr, d_size, d_rw, d_wdata,
        input  d_gnt, d_wready, d_rvalid, d_rdata, d_done,
        input  mem_address, mem_data_in, mem_access_size, mem_rw, mem_enable,
        output mem_data_out
    );

endinterface
`default_nettype wire

// File: rtl/mem_rd_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_rd_pipe                                                  |
// | Description : READ_LATENCY-deep {valid, owner} tracker for read beats.     |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mem_rd_pipe
    import mem_ctrl_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  wire logic    clock,
    input  wire logic    reset,
    input  wire logic    i_flush,
    input  wire rd_tag_t i_tag,
    output rd_tag_t      o_tag,
    output logic         o_busy
);

    rd_tag_t r_stage_q [READ_LATENCY];
    rd_tag_t w_stage_d [READ_LATENCY];

    always_comb begin
        for (int i = 0; i < READ_LATENCY; i++) begin
            w_stage_d[i] = '0;
        end
        if (!i_flush) begin
            w_stage_d[0] = i_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                w_stage_d[i] = r_stage_q[i-1];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_stage_q[i] <= w_stage_d[i];
            end
        end
    end

    assign o_tag = r_stage_q[READ_LATENCY-1];

    // The last stage is returning data this cycle, so it does not count as pending.
    generate
        if (READ_LATENCY > 1) begin : g_busy
            always_comb begin
                o_busy = 1'b0;
                for (int i = 0; i < READ_LATENCY - 1; i++) begin
                    o_busy = o_busy | r_stage_q[i].valid;
                end
            end
        end else begin : g_no_busy
            assign o_busy = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Round-robin fetch/data arbiter sequencing bursts to memory.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mem_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_W       = 32
) (
    input  wire logic    clock,
    input  wire logic    reset,
    mem_arbiter_if.slave bus
);

    state_t            r_state_q,      w_state_d;
    owner_t            r_owner_q,      w_owner_d;
    owner_t            r_last_owner_q, w_last_owner_d;
    owner_t            w_pick;
    logic [ADDR_W-1:0] r_addr_q,       w_addr_d;
    logic [4:0]        r_beats_q,      w_beats_d;
    logic [4:0]        r_beat_q,       w_beat_d;
    logic              r_rw_q,         w_rw_d;
    logic              r_gnt_if_q,     w_gnt_if_d;
    logic              r_gnt_d_q,      w_gnt_d_d;
    logic              r_alive_q,      w_alive_d;

    logic              w_in_burst;
    logic              w_last_beat;
    logic              w_flush;
    logic              w_pipe_busy;
    rd_tag_t           w_tag_in;
    rd_tag_t           w_tag_out;

    assign w_in_burst  = (r_state_q == BURST);
    assign w_last_beat = (r_beat_q == r_beats_q - 5'd1);
    assign w_flush     = (r_state_q == IDLE);
    assign w_alive_d   = 1'b1;

    always_comb begin
        w_state_d      = r_state_q;
        w_owner_d      = r_owner_q;
        w_last_owner_d = r_last_owner_q;
        w_addr_d       = r_addr_q;
        w_beats_d      = r_beats_q;
        w_beat_d       = r_beat_q;
        w_rw_d         = r_rw_q;
        w_pick         = OWN_IF;

        case (r_state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    if (bus.if_req && bus.d_req) begin
                        w_pick = (r_last_owner_q == OWN_D) ? OWN_IF : OWN_D;
                    end else begin
                        w_pick = bus.if_req ? OWN_IF : OWN_D;
                    end
                    w_owner_d = w_pick;
                    if (w_pick == OWN_IF) begin
                        w_addr_d  = bus.if_addr & ~ADDR_W'(3);
                        w_beats_d = size_to_beats(bus.if_size);
                        w_rw_d    = 1'b1;
                    end else begin
                        w_addr_d  = bus.d_addr & ~ADDR_W'(3);
                        w_beats_d = size_to_beats(bus.d_size);
                        w_rw_d    = bus.d_rw;
                    end
                    w_beat_d  = '0;
                    w_state_d = BURST;
                end
            end
            BURST: begin
                w_beat_d = r_beat_q + 5'd1;
                if (w_last_beat) begin
                    w_state_d = r_rw_q ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (!w_pipe_busy) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                w_last_owner_d = r_owner_q;
                w_state_d      = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Grant follows ownership of the next state so it drops as DONE begins.
        w_gnt_if_d = ((w_state_d == BURST) || (w_state_d == DRAIN)) && (w_owner_d == OWN_IF);
        w_gnt_d_d  = ((w_state_d == BURST) || (w_state_d == DRAIN)) && (w_owner_d == OWN_D);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q      <= IDLE;
            r_owner_q      <= OWN_IF;
            r_last_owner_q <= OWN_D;
            r_addr_q       <= '0;
            r_beats_q      <= '0;
            r_beat_q       <= '0;
            r_rw_q         <= 1'b0;
            r_gnt_if_q     <= 1'b0;
            r_gnt_d_q      <= 1'b0;
            r_alive_q      <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_owner_q      <= w_owner_d;
            r_last_owner_q <= w_last_owner_d;
            r_addr_q       <= w_addr_d;
            r_beats_q      <= w_beats_d;
            r_beat_q       <= w_beat_d;
            r_rw_q         <= w_rw_d;
            r_gnt_if_q     <= w_gnt_if_d;
            r_gnt_d_q      <= w_gnt_d_d;
            r_alive_q      <= w_alive_d;
        end
    end

    assign w_tag_in.valid = w_in_burst && r_rw_q;
    assign w_tag_in.owner = r_owner_q;

    mem_rd_pipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clock   (clock),
        .reset   (reset),
        .i_flush (w_flush),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out),
        .o_busy  (w_pipe_busy)
    );

    // mem_rw idles as read, but stays 0 until the first clock after reset.
    assign bus.mem_enable      = w_in_burst;
    assign bus.mem_address     = w_in_burst ? (r_addr_q + ADDR_W'(r_beat_q) * ADDR_W'(WORD_BYTES)) : '0;
    assign bus.mem_rw          = w_in_burst ? r_rw_q : r_alive_q;
    assign bus.mem_data_in     = w_in_burst ? bus.d_wdata : '0;
    assign bus.mem_access_size = SIZE_1W;

    assign bus.if_gnt    = r_gnt_if_q;
    assign bus.d_gnt     = r_gnt_d_q;
    assign bus.d_wready  = w_in_burst && !r_rw_q && (r_owner_q == OWN_D);

    assign bus.if_rvalid = w_tag_out.valid && (w_tag_out.owner == OWN_IF);
    assign bus.d_rvalid  = w_tag_out.valid && (w_tag_out.owner == OWN_D);
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_data_out : '0;
    assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_data_out : '0;

    assign bus.if_done   = (r_state_q == DONE) && (r_owner_q == OWN_IF);
    assign bus.d_done    = (r_state_q == DONE) && (r_owner_q == OWN_D);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Scoreboard bench for mem_arbiter (latency 1 and latency 3).  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        logic        r;
    } exp_t;

    // Channel per DUT k: k*5 + {0 addr, 1 if_rd, 2 d_rd, 3 if_done, 4 d_done}
    exp_t sb [10][$];

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    bit   b_finished = 1'b0;

    logic [31:0] memA [logic [29:0]];
    logic [31:0] memB [logic [29:0]];
    logic [31:0] rdA;
    logic [31:0] rdB [3];
    logic [31:0] w [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter_if #(.ADDR_W(32)) ifa ();
    mem_arbiter_if #(.ADDR_W(32)) ifb ();

    mem_arbiter #(.READ_LATENCY(1), .ADDR_W(32)) dut_a (.clock(clk), .reset(rst_a), .bus(ifa.slave));
    mem_arbiter #(.READ_LATENCY(3), .ADDR_W(32)) dut_b (.clock(clk), .reset(rst_b), .bus(ifb.slave));

    // Memory models: writes land at the edge, reads appear after the latency.
    always @(posedge clk) begin
        if (ifa.mem_enable && !ifa.mem_rw) memA[ifa.mem_address[31:2]] = ifa.mem_data_in;
        if (ifa.mem_enable && ifa.mem_rw)
            rdA <= memA.exists(ifa.mem_address[31:2]) ? memA[ifa.mem_address[31:2]] : 32'h0;
        else
            rdA <= 32'h0;
        if (ifb.mem_enable && ifb.mem_rw)
            rdB[0] <= memB.exists(ifb.mem_address[31:2]) ? memB[ifb.mem_address[31:2]] : 32'h0;
        else
            rdB[0] <= 32'h0;
        rdB[1] <= rdB[0];
        rdB[2] <= rdB[1];
    end
    assign ifa.mem_data_out = rdA;
    assign ifb.mem_data_out = rdB[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int ch, input int c, input logic [31:0] a, input logic [31:0] b, input logic r);
        exp_t e;
        e.cyc = c; e.a = a; e.b = b; e.r = r;
        sb[ch].push_back(e);
    endtask

    task automatic pop_chk(input int k, input int ch, input string nm,
                           input logic [31:0] a, input logic [31:0] b, input logic r);
        exp_t e;
        string s;
        s = $sformatf("dut%0d %s", k, nm);
        if (sb[k*5+ch].size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s unexpected: got 0x%08h at cycle %0d expected no event", s, a, cyc);
        end else begin
            e = sb[k*5+ch].pop_front();
            chk({s, " cycle"}, cyc, e.cyc);
            chk({s, " value"}, a, e.a);
            if (ch == 0) begin
                chk({s, " rw"}, {31'b0, r}, {31'b0, e.r});
                if (!e.r) chk({s, " wdata"}, b, e.b);
            end
        end
    endtask

    task automatic mon(input int k, input logic en, input logic [31:0] addr, input logic rw,
                       input logic [31:0] wd, input logic iv, input logic [31:0] idat,
                       input logic dv, input logic [31:0] ddat, input logic idn, input logic ddn);
        if (en)  pop_chk(k, 0, "mem_address", addr, wd, rw);
        if (iv)  pop_chk(k, 1, "if_rdata", idat, 32'h0, 1'b0);
        if (dv)  pop_chk(k, 2, "d_rdata", ddat, 32'h0, 1'b0);
        if (idn) pop_chk(k, 3, "if_done", 32'h0, 32'h0, 1'b0);
        if (ddn) pop_chk(k, 4, "d_done", 32'h0, 32'h0, 1'b0);
    endtask

    always @(negedge clk) begin
        mon(0, ifa.mem_enable, ifa.mem_address, ifa.mem_rw, ifa.mem_data_in, ifa.if_rvalid,
            ifa.if_rdata, ifa.d_rvalid, ifa.d_rdata, ifa.if_done, ifa.d_done);
        mon(1, ifb.mem_enable, ifb.mem_address, ifb.mem_rw, ifb.mem_data_in, ifb.if_rvalid,
            ifb.if_rdata, ifb.d_rvalid, ifb.d_rdata, ifb.if_done, ifb.d_done);
    end

    function automatic logic [31:0] outs_a();
        return {31'b0, |{ifa.if_gnt, ifa.if_rvalid, ifa.if_rdata, ifa.if_done, ifa.d_gnt,
                         ifa.d_wready, ifa.d_rvalid, ifa.d_rdata, ifa.d_done, ifa.mem_address,
                         ifa.mem_data_in, ifa.mem_access_size, ifa.mem_rw, ifa.mem_enable}};
    endfunction

    function automatic logic [31:0] outs_b();
        return {31'b0, |{ifb.if_gnt, ifb.if_rvalid, ifb.if_rdata, ifb.if_done, ifb.d_gnt,
                         ifb.d_wready, ifb.d_rvalid, ifb.d_rdata, ifb.d_done, ifb.mem_address,
                         ifb.mem_data_in, ifb.mem_access_size, ifb.mem_rw, ifb.mem_enable}};
    endfunction

    // Immediate-grant transaction on DUT A; called and returning at posedge+1.
    task automatic run_a(input bit is_if, input logic [31:0] addr, input logic [1:0] size,
                         input logic rw, input logic [31:0] wr [16]);
        int          c0, n, k, t;
        logic [31:0] base;
        logic        dn;
        n    = (size == 2'b00) ? 1 : (size == 2'b01) ? 4 : (size == 2'b10) ? 8 : 16;
        c0   = cyc;
        base = {addr[31:2], 2'b00};
        for (int i = 0; i < n; i++) begin
            push(0, c0 + 1 + i, base + 32'(4 * i), wr[i], rw);
            if (rw) push(is_if ? 1 : 2, c0 + 2 + i, wr[i], 32'h0, 1'b0);
        end
        push(is_if ? 3 : 4, rw ? c0 + n + 2 : c0 + n + 1, 32'h0, 32'h0, 1'b0);
        if (is_if) begin
            ifa.if_req = 1'b1; ifa.if_addr = addr; ifa.if_size = size;
        end else begin
            ifa.d_req = 1'b1; ifa.d_addr = addr; ifa.d_size = size; ifa.d_rw = rw; ifa.d_wdata = wr[0];
        end
        k = 0;
        for (t = 0; t < 60; t++) begin
            @(negedge clk);
            if (ifa.d_wready) k++;
            dn = is_if ? ifa.if_done : ifa.d_done;
            @(posedge clk); #1;
            if (dn) break;
            if (k < 16) ifa.d_wdata = wr[k];
        end
        if (t == 60) chk("dut0 done timeout", 32'h0, 32'h1);
        ifa.if_req = 1'b0;
        ifa.d_req  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // DUT B: 16-beat read with READ_LATENCY=3
    initial begin
        int c0, t;
        rst_b = 1'b1;
        ifb.if_req = 1'b0; ifb.if_addr = '0; ifb.if_size = '0;
        ifb.d_req = 1'b0; ifb.d_addr = '0; ifb.d_size = '0; ifb.d_rw = 1'b1; ifb.d_wdata = '0;
        for (int i = 0; i < 16; i++) memB[30'(32'h2000_C000 + i)] = 32'hB000_0000 + i;
        repeat (3) @(posedge clk);
        #1;
        chk("dut1 reset outputs", outs_b(), 32'h0);
        rst_b = 1'b0;
        @(posedge clk); #1;
        c0 = cyc;
        for (int i = 0; i < 16; i++) begin
            push(5, c0 + 1 + i, 32'h8003_0000 + 32'(4 * i), 32'h0, 1'b1);
            push(7, c0 + 4 + i, 32'hB000_0000 + i, 32'h0, 1'b0);
        end
        push(9, c0 + 20, 32'h0, 32'h0, 1'b0);
        ifb.d_req = 1'b1; ifb.d_addr = 32'h8003_0000; ifb.d_size = 2'b11; ifb.d_rw = 1'b1;
        for (t = 0; t < 60; t++) begin
            @(posedge clk); #1;
            if (cyc == c0 + 18) chk("dut1 mem_enable in drain", {31'b0, ifb.mem_enable}, 32'h0);
            if (ifb.d_done) break;
        end
        if (t == 60) chk("dut1 done timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
        ifb.d_req = 1'b0;
        b_finished = 1'b1;
    end

    // DUT A: directed sequence
    initial begin
        int c0;
        rst_a = 1'b1;
        ifa.if_req = 1'b0; ifa.if_addr = '0; ifa.if_size = '0;
        ifa.d_req = 1'b0; ifa.d_addr = '0; ifa.d_size = '0; ifa.d_rw = 1'b1; ifa.d_wdata = '0;
        memA[30'h2000_8000] = 32'hDEAD_BEEF;
        memA[30'h2000_8001] = 32'h1234_5678;
        memA[30'h2000_8040] = 32'h0101_0101;
        memA[30'h2000_8080] = 32'h0202_0202;
        for (int i = 0; i < 8; i++) memA[30'(32'h2000_8010 + i)] = 32'h4000_0000 + i;
        for (int i = 0; i < 16; i++) w[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("dut0 reset outputs", outs_a(), 32'h0);
        rst_a = 1'b0;
        @(posedge clk); #1;

        w[0] = 32'hDEAD_BEEF;
        run_a(1'b1, 32'h8002_0000, 2'b00, 1'b1, w);

        w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
        run_a(1'b0, 32'h8002_0010, 2'b01, 1'b0, w);
        run_a(1'b0, 32'h8002_0010, 2'b01, 1'b1, w);

        // Simultaneous requests: fetch, data, fetch
        c0 = cyc;
        push(0, c0 + 1, 32'h8002_0100, 32'h0, 1'b1);
        push(0, c0 + 5, 32'h8002_0200, 32'h0, 1'b1);
        push(0, c0 + 9, 32'h8002_0100, 32'h0, 1'b1);
        push(1, c0 + 2, 32'h0101_0101, 32'h0, 1'b0);
        push(1, c0 + 10, 32'h0101_0101, 32'h0, 1'b0);
        push(2, c0 + 6, 32'h0202_0202, 32'h0, 1'b0);
        push(3, c0 + 3, 32'h0, 32'h0, 1'b0);
        push(3, c0 + 11, 32'h0, 32'h0, 1'b0);
        push(4, c0 + 7, 32'h0, 32'h0, 1'b0);
        ifa.if_req = 1'b1; ifa.if_addr = 32'h8002_0100; ifa.if_size = 2'b00;
        ifa.d_req = 1'b1; ifa.d_addr = 32'h8002_0200; ifa.d_size = 2'b00; ifa.d_rw = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(posedge clk); #1;
            if (t == 1) chk("dut0 gnt first {if,d}", {30'b0, ifa.if_gnt, ifa.d_gnt}, 32'h2);
            if (t == 5) chk("dut0 gnt second {if,d}", {30'b0, ifa.if_gnt, ifa.d_gnt}, 32'h1);
            if (t == 9) chk("dut0 gnt third {if,d}", {30'b0, ifa.if_gnt, ifa.d_gnt}, 32'h2);
        end
        ifa.if_req = 1'b0;
        ifa.d_req  = 1'b0;
        @(posedge clk); #1;

        w[0] = 32'h1234_5678;
        run_a(1'b0, 32'h8002_0006, 2'b00, 1'b1, w);

        // Reset during beat 5 of an 8-word read
        c0 = cyc;
        for (int i = 0; i < 4; i++) push(0, c0 + 1 + i, 32'h8002_0040 + 32'(4 * i), 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) push(2, c0 + 2 + i, 32'h4000_0000 + i, 32'h0, 1'b0);
        ifa.d_req = 1'b1; ifa.d_addr = 32'h8002_0040; ifa.d_size = 2'b10; ifa.d_rw = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_a = 1'b1;
        ifa.d_req = 1'b0;
        #1;
        chk("dut0 outputs in mid-burst reset", outs_a(), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(posedge clk); #1;

        w[0] = 32'hDEAD_BEEF;
        run_a(1'b0, 32'h8002_0000, 2'b00, 1'b1, w);

        for (int t = 0; t < 100 && !b_finished; t++) @(posedge clk);
        chk("dut1 sequence finished", {31'b0, b_finished}, 32'h1);
        repeat (4) @(posedge clk);
        for (int ch = 0; ch < 10; ch++) chk($sformatf("leftover expectations ch%0d", ch), sb[ch].size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
